// File: rtl/cbs_scan_controller.sv
// rtl/cbs_scan_controller.sv - CBS convolution scan sequencer with result tagging (option: CBS_PAD_EN)
module cbs_scan_controller #(
    parameter int IMG_W      = 416,
    parameter int IMG_H      = 416,
    parameter int STRIDE     = 1,
    parameter int MAC_CYCLES = 6,
    parameter int PIPE_LAT   = 3,
    parameter int CNT_W      = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          mac_clear,
    output logic                          mac_en,
    output logic [$clog2(MAC_CYCLES)-1:0] mac_phase,
    output logic [CNT_W-1:0]              win_row,
    output logic [CNT_W-1:0]              win_col,
    output logic                          pad_top,
    output logic                          pad_bottom,
    output logic                          pad_left,
    output logic                          pad_right,
    output logic                          result_valid,
    output logic [CNT_W-1:0]              counter_Row_output,
    output logic [CNT_W-1:0]              counter_Col_output
);

    localparam int PW = $clog2(MAC_CYCLES);
    localparam int EW = 1 + 2 * CNT_W;
    localparam int L  = PIPE_LAT - 1;
    localparam logic [CNT_W-1:0] STEP = CNT_W'(STRIDE);
    localparam logic [PW-1:0] LAST_PH = PW'(MAC_CYCLES - 1);

`ifdef CBS_PAD_EN
    // Zero padding: every pixel is a window centre
    localparam logic [CNT_W-1:0] FIRST   = '0;
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
`else
    // Valid convolution: centres keep the whole 3x3 footprint inside the image
    localparam logic [CNT_W-1:0] FIRST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 2);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 2);
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [CNT_W-1:0] out_row;
    logic [CNT_W-1:0] out_col;
    logic [EW-1:0]   dl   [PIPE_LAT];
    logic [EW-1:0]   prev [PIPE_LAT];
    logic [EW-1:0]   feed;
    logic            last_phase;
    logic            stall;
    logic            win_done;
    logic            col_wrap;
    logic            row_wrap;

    assign last_phase = (phase == LAST_PH);
    // Freeze only at the final phase so an unaccepted result is never overwritten
    assign stall      = last_phase && result_valid && !out_ready;
    assign mac_en     = (state == RUN) && !stall;
    assign mac_clear  = mac_en && (phase == '0);
    assign mac_phase  = phase;
    assign win_done   = mac_en && last_phase;
    assign col_wrap   = (win_col + STEP) > COL_MAX;
    assign row_wrap   = (win_row + STEP) > ROW_MAX;
    assign feed       = win_done ? {1'b1, out_row, out_col} : '0;

    assign result_valid       = dl[L][EW-1];
    assign counter_Row_output = dl[L][2*CNT_W-1:CNT_W];
    assign counter_Col_output = dl[L][CNT_W-1:0];

`ifdef CBS_PAD_EN
    assign pad_top    = (state == RUN) && (win_row == '0);
    assign pad_bottom = (state == RUN) && (win_row == ROW_MAX);
    assign pad_left   = (state == RUN) && (win_col == '0);
    assign pad_right  = (state == RUN) && (win_col == COL_MAX);
`else
    assign pad_top    = 1'b0;
    assign pad_bottom = 1'b0;
    assign pad_left   = 1'b0;
    assign pad_right  = 1'b0;
`endif

    // Source of each delay-line stage: new tag at the head, previous stage elsewhere
    always_comb begin
        prev[0] = feed;
        for (int i = 1; i < PIPE_LAT; i++) prev[i] = dl[i-1];
    end

    // Scan FSM: phase counter, raster walk over window centres, frame handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            win_row <= '0;
            win_col <= '0;
            out_row <= '0;
            out_col <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        phase   <= '0;
                        win_row <= FIRST;
                        win_col <= FIRST;
                        out_row <= '0;
                        out_col <= '0;
                    end
                end
                RUN: begin
                    if (mac_en) begin
                        if (!last_phase) begin
                            phase <= phase + 1'b1;
                        end else begin
                            phase <= '0;
                            if (!col_wrap) begin
                                win_col <= win_col + STEP;
                                out_col <= out_col + 1'b1;
                            end else if (!row_wrap) begin
                                win_col <= FIRST;
                                out_col <= '0;
                                win_row <= win_row + STEP;
                                out_row <= out_row + 1'b1;
                            end else begin
                                state   <= DRAIN;
                                win_row <= '0;
                                win_col <= '0;
                                out_row <= '0;
                                out_col <= '0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (result_valid && out_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result tag delay line; the last stage doubles as the held output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
        end else begin
            for (int i = 0; i < PIPE_LAT - 1; i++) begin
                if (!stall) dl[i] <= prev[i];
            end
            if (!result_valid || out_ready) dl[L] <= prev[L];
        end
    end

endmodule

// File: tb/tb_cbs_scan_controller.sv
// tb/tb_cbs_scan_controller.sv - scoreboard bench for cbs_scan_controller
module tb_cbs_scan_controller;

    localparam int IW = 4;
    localparam int IH = 3;
    localparam int BIG = 1000000;
`ifdef CBS_PAD_EN
    localparam int PADV = 1;
`else
    localparam int PADV = 0;
`endif

    typedef struct {int r; int c; int t;} ent_t;

    logic clk, reset, start0, start1, ready0, ready1;
    logic busy0, done0, clr0, en0, pt0, pb0, pl0, pr0, rv0;
    logic busy1, done1, clr1, en1, pt1, pb1, pl1, pr1, rv1;
    logic [2:0]  ph0, ph1;
    logic [14:0] wr0, wc0, or0, oc0, wr1, wc1, or1, oc1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    ent_t rq0[$], cq0[$], rq1[$], cq1[$];
    int   dq0[$], dq1[$];

    cbs_scan_controller #(.IMG_W(IW), .IMG_H(IH), .STRIDE(1), .MAC_CYCLES(6), .PIPE_LAT(3), .CNT_W(15)) u0 (
        .clk(clk), .reset(reset), .start(start0), .out_ready(ready0), .busy(busy0), .done(done0),
        .mac_clear(clr0), .mac_en(en0), .mac_phase(ph0), .win_row(wr0), .win_col(wc0),
        .pad_top(pt0), .pad_bottom(pb0), .pad_left(pl0), .pad_right(pr0), .result_valid(rv0),
        .counter_Row_output(or0), .counter_Col_output(oc0));

    cbs_scan_controller #(.IMG_W(IW), .IMG_H(IH), .STRIDE(2), .MAC_CYCLES(6), .PIPE_LAT(3), .CNT_W(15)) u1 (
        .clk(clk), .reset(reset), .start(start1), .out_ready(ready1), .busy(busy1), .done(done1),
        .mac_clear(clr1), .mac_en(en1), .mac_phase(ph1), .win_row(wr1), .win_col(wc1),
        .pad_top(pt1), .pad_bottom(pb1), .pad_left(pl1), .pad_right(pr1), .result_valid(rv1),
        .counter_Row_output(or1), .counter_Col_output(oc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_ent(input string nm, input ent_t e, input int r, input int c);
        chk({nm, "_row"}, r, e.r);
        chk({nm, "_col"}, c, e.c);
        chk({nm, "_cycle"}, cyc, e.t);
    endtask

    function automatic void dims(input int inst, output int nr, output int nc, output int first, output int s);
        s = (inst == 0) ? 1 : 2;
`ifdef CBS_PAD_EN
        first = 0; nr = (IH - 1) / s + 1; nc = (IW - 1) / s + 1;
`else
        first = 1; nr = (IH - 3) / s + 1; nc = (IW - 3) / s + 1;
`endif
    endfunction

    // Expected centres, results and done for a frame started at t; stall = backpressure 9..19
    task automatic push_frame(input int inst, input int t, input int stall, input int cut);
        int nr, nc, first, s, cc, rc;
        ent_t e;
        dims(inst, nr, nc, first, s);
        rc = 0;
        for (int n = 0; n < nr * nc; n++) begin
            if (stall == 0 || n < 2) cc = t + 1 + 6 * n;
            else cc = t + 21 + 6 * (n - 2);
            if (stall == 0) rc = t + 9 + 6 * n;
            else if (n == 0) rc = t + 20;
            else rc = t + 23 + 6 * (n - 1);
            e.r = first + s * (n / nc); e.c = first + s * (n % nc); e.t = cc;
            if (cc <= cut) begin
                if (inst == 0) cq0.push_back(e); else cq1.push_back(e);
            end
            e.r = n / nc; e.c = n % nc; e.t = rc;
            if (rc <= cut) begin
                if (inst == 0) rq0.push_back(e); else rq1.push_back(e);
            end
        end
        if (rc + 1 <= cut) begin
            if (inst == 0) dq0.push_back(rc + 1); else dq1.push_back(rc + 1);
        end
    endtask

    // Monitor: pop and compare whenever a DUT presents an event
    always @(negedge clk) begin
        if (rv0 && ready0) begin
            if (rq0.size() == 0) chk("res0_extra", 1, 0);
            else cmp_ent("res0", rq0.pop_front(), or0, oc0);
        end
        if (clr0) begin
            if (cq0.size() == 0) chk("win0_extra", 1, 0);
            else cmp_ent("win0", cq0.pop_front(), wr0, wc0);
        end
        if (done0) begin
            if (dq0.size() == 0) chk("done0_extra", 1, 0);
            else chk("done0_cycle", cyc, dq0.pop_front());
            chk("busy0_at_done", busy0, 0);
        end
        if (rv1 && ready1) begin
            if (rq1.size() == 0) chk("res1_extra", 1, 0);
            else cmp_ent("res1", rq1.pop_front(), or1, oc1);
        end
        if (clr1) begin
            if (cq1.size() == 0) chk("win1_extra", 1, 0);
            else cmp_ent("win1", cq1.pop_front(), wr1, wc1);
        end
        if (done1) begin
            if (dq1.size() == 0) chk("done1_extra", 1, 0);
            else chk("done1_cycle", cyc, dq1.pop_front());
        end
    end

    task automatic drive_at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string nm);
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (rq0.size() + cq0.size() + dq0.size() + rq1.size() + cq1.size() + dq1.size() == 0
                && !busy0 && !busy1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_timeout"}, ok, 1);
    endtask

    task automatic start_u0(input int stall, input int cut_rel, output int t);
        drive_at(cyc + 1);
        t = cyc;
        push_frame(0, t, stall, t + cut_rel);
        start0 = 1'b1;
        drive_at(t + 1);
        start0 = 1'b0;
        @(negedge clk);
        chk("t1_busy", busy0, 1);
        chk("t1_mac_clear", clr0, 1);
        chk("t1_phase", ph0, 0);
        chk("t1_pad_top", pt0, PADV);
        chk("t1_pad_left", pl0, PADV);
        chk("t1_pad_bottom", pb0, 0);
    endtask

    initial begin
        int t, dn, nr, nc, first, s;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
        drive_at(3);
        @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_mac_en", en0, 0);
        chk("rst_valid", rv0, 0);
        chk("rst_win_row", wr0, 0);
        chk("rst_win_col", wc0, 0);
        chk("rst_busy1", busy1, 0);
        reset = 1'b0;

        // Plain frame, always ready
        start_u0(0, BIG, t);
        wait_idle("frame");

        // Backpressure: out_ready low during cycles 9..19, accepted at 20
        start_u0(1, BIG, t);
        drive_at(t + 9);
        ready0 = 1'b0;
        drive_at(t + 15);
        @(negedge clk);
        chk("bp_mac_en", en0, 0);
        chk("bp_phase", ph0, 5);
        chk("bp_valid", rv0, 1);
        chk("bp_res_col", oc0, 0);
        chk("bp_win_col", wc0, PADV ? 1 : 2);
        drive_at(t + 20);
        ready0 = 1'b1;
        wait_idle("backpressure");

        // Reset mid-frame at cycle 30
        start_u0(0, 30, t);
        drive_at(t + 30);
        reset = 1'b1;
        drive_at(t + 31);
        @(negedge clk);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_valid", rv0, 0);
        chk("mid_rst_mac_en", en0, 0);
        chk("mid_rst_row", or0, 0);
        chk("mid_rst_pad", pt0 | pl0, 0);
        reset = 1'b0;
        wait_idle("after_reset");
        start_u0(0, BIG, t);
        wait_idle("refill");

        // Mid-frame start ignored; start held across done relaunches at once
        start_u0(0, BIG, t);
        dims(0, nr, nc, first, s);
        dn = t + 6 * nr * nc + 4;
        push_frame(0, dn, 0, BIG);
        drive_at(t + 10);
        start0 = 1'b1;
        drive_at(t + 11);
        start0 = 1'b0;
        drive_at(dn - 3);
        start0 = 1'b1;
        drive_at(dn + 1);
        start0 = 1'b0;
        wait_idle("back_to_back");

        // Stride 2 on the second instance
        drive_at(cyc + 1);
        t = cyc;
        push_frame(1, t, 0, BIG);
        start1 = 1'b1;
        drive_at(t + 1);
        start1 = 1'b0;
        wait_idle("stride2");

        chk("queues_empty", rq0.size() + cq0.size() + dq0.size() + rq1.size() + cq1.size() + dq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbs_scan_controller.md
# cbs_scan_controller

Sequencer for the CBS (Conv-BN-SiLU) convolution datapath. It walks the output feature map in raster order and issues one multi-cycle MAC window per output pixel as clock-enable strobes. It tags each pipelined convolution result with its output row/column and applies ready/valid backpressure. It sits between the layer scheduler (start/done) and the CBS datapath, replacing a divided clock with single-clock enables.

## Interface

Parameters:
- IMG_W, 416, input feature-map width (pixels)
- IMG_H, 416, input feature-map height
- STRIDE, 1, window step in rows and columns (1 or 2)
- MAC_CYCLES, 6, cycles per window (≥2)
- PIPE_LAT, 3, cycles from a window's last MAC phase to its result at datapath output; must be < MAC_CYCLES
- CNT_W, 15, row/column counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled in IDLE only
- out_ready  in  1  downstream accepts the current result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame
- mac_clear  out  1  clear accumulator; high in phase 0 of each window
- mac_en  out  1  datapath MAC enable
- mac_phase  out  $clog2(MAC_CYCLES)  current phase within window
- win_row, win_col  out  CNT_W each  input-plane centre of current window
- pad_top, pad_bottom, pad_left, pad_right  out  1 each  window tap lies outside the image
- result_valid  out  1  datapath result is valid this cycle
- counter_Row_output, counter_Col_output  out  CNT_W each  output-plane coordinate of the valid result

## Operation

- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 → RUN, phase=0, window at the first centre.
  - start is ignored in RUN and DRAIN.
- RUN:
  - mac_en=1 every cycle unless stalled. mac_clear=mac_en&&(phase==0).
  - Phase wraps MAC_CYCLES-1→0, and the window advances on that wrap.
  - Column advances by STRIDE. If the next column passes the last centre, column returns to the first centre and row advances by STRIDE.
  - After the last window's final phase → DRAIN.
- Result tagging:
  - A delay line of depth PIPE_LAT carries "window finished" plus output coordinates.
  - Output coordinates are (centre − first centre)/STRIDE, so they start at 0.
  - When an entry emerges, result_valid=1 with its coordinates. They are held until out_ready=1.
- Stall:
  - In phase MAC_CYCLES-1 with result_valid=1 and out_ready=0: mac_en=0, and phase, window and delay line all hold.
  - At most one result is ever outstanding, because PIPE_LAT < MAC_CYCLES.
- DRAIN: wait until the last result is accepted (result_valid&&out_ready), then done=1 for one cycle, busy=0, and the FSM returns to IDLE.
- Counter arithmetic is unsigned, CNT_W bits. There is no wrap inside a frame.

## Timing

- Reset value of every output is 0, and the FSM goes to IDLE. This applies in any state: reset mid-frame discards the in-flight window and any pending result, with no done pulse.
- If start is sampled at cycle t:
  - busy=1 and phase 0 of window 0 occur at t+1.
  - With no stalls, window n phase 0 is at t+1+n·MAC_CYCLES.
- A window's result_valid rises PIPE_LAT cycles after the cycle in which its last phase executed with mac_en=1.
- done occurs one cycle after acceptance of the last result. busy falls in the same cycle as done. start may be reasserted in the cycle after done.
- If out_ready drops in the same cycle result_valid rises, the stall applies at the next window's last phase. Earlier phases proceed.

## Configuration

- CBS_PAD_EN defined (zero padding):
  - Centres span rows 0..IMG_H-1 and columns 0..IMG_W-1, in steps of STRIDE.
  - pad_* flags assert when a 3×3 tap falls outside the image, e.g. pad_top when win_row==0.
- CBS_PAD_EN undefined (valid convolution):
  - Centres span 1..IMG_H-2 and 1..IMG_W-2.
  - pad_* flags are tied to 0.

## Test plan

All scenarios use IMG_W=4, IMG_H=3, STRIDE=1, MAC_CYCLES=6, PIPE_LAT=3.

- CBS_PAD_EN defined, out_ready=1, start at cycle 0:
  - 12 results, coordinates (0,0)…(2,3) in raster order.
  - First result_valid at cycle 9. Last result at cycle 75, done at cycle 76.
  - pad_top and pad_left both high in window 0.
- CBS_PAD_EN undefined, same stimulus:
  - 2 results, (0,0) then (0,1), at cycles 9 and 15. done at cycle 16.
  - win_row=1 throughout. pad_* all 0.
- Backpressure: out_ready=0 from cycle 9 to cycle 20:
  - result (0,0) is held through cycles 9–20.
  - Window 1 freezes at phase 5 with mac_en=0, while window/result coordinates stay stable.
  - Window 1 resumes after acceptance at cycle 20. No result is lost or duplicated.
- Reset asserted at cycle 30 of a frame:
  - All outputs are 0 at cycle 31 and no done pulse occurs.
  - A new start produces a full, correct frame.
- start pulsed at cycle 10 mid-frame is ignored (frame count unchanged). start held high across done immediately launches a second identical frame.
- STRIDE=2 with CBS_PAD_EN defined:
  - Centres (0,0),(0,2),(2,0),(2,2).
  - Outputs (0,0),(0,1),(1,0),(1,1).
